// File: rtl/alu_if.sv
// Execute-stage ALU bus: instruction and operands in, registered result and flags out.
interface alu_if;
   logic [31:0] instruction;
   logic [31:0] regA;
   logic [31:0] regB;
   logic [31:0] result;
   logic [2:0]  flags;

   modport master (
      output instruction,
      output regA,
      output regB,
      input  result,
      input  flags
   );

   modport slave (
      input  instruction,
      input  regA,
      input  regB,
      output result,
      output flags
   );
endinterface

// File: rtl/alu.sv
// 32-bit MIPS-style ALU, one-cycle registered result with zero/negative/overflow flags.
// Shift functs are built only when ALU_SHIFT_EN is defined; otherwise they decode as unsupported.
module alu (
   input  logic  clk,
   input  logic  rst_n,
   alu_if.slave  bus
);

   logic [5:0]  op_s;
   logic [5:0]  funct_s;
   logic [31:0] opnd_s_s;
   logic [31:0] opnd_t_s;
   logic [31:0] imm_se_s;
   logic [31:0] imm_ze_s;
   logic [31:0] sum_s;
   logic [31:0] diff_s;
   logic [31:0] sum_imm_s;
   logic        add_ovf_s;
   logic        sub_ovf_s;
   logic        addi_ovf_s;
   logic        slt_s;
   logic        sltu_s;
   logic        slti_s;
   logic        sltiu_s;

   logic [31:0] res_s;
   logic        valid_s;
   logic        cmp_s;
   logic        ovf_s;
   logic [2:0]  flags_s;

   assign op_s      = bus.instruction[31:26];
   assign funct_s   = bus.instruction[5:0];
   assign opnd_s_s  = bus.instruction[21] ? bus.regB : bus.regA;
   assign opnd_t_s  = bus.instruction[16] ? bus.regB : bus.regA;
   assign imm_se_s  = {{16{bus.instruction[15]}}, bus.instruction[15:0]};
   assign imm_ze_s  = {16'h0000, bus.instruction[15:0]};

   assign sum_s     = opnd_s_s + opnd_t_s;
   assign diff_s    = opnd_s_s - opnd_t_s;
   assign sum_imm_s = opnd_s_s + imm_se_s;

   // Signed overflow: like-signed operands producing an opposite-signed sum.
   assign add_ovf_s  = (opnd_s_s[31] == opnd_t_s[31]) && (sum_s[31] != opnd_s_s[31]);
   assign sub_ovf_s  = (opnd_s_s[31] != opnd_t_s[31]) && (diff_s[31] != opnd_s_s[31]);
   assign addi_ovf_s = (opnd_s_s[31] == imm_se_s[31]) && (sum_imm_s[31] != opnd_s_s[31]);

   assign slt_s   = ($signed(opnd_s_s) < $signed(opnd_t_s));
   assign sltu_s  = (opnd_s_s < opnd_t_s);
   assign slti_s  = ($signed(opnd_s_s) < $signed(imm_se_s));
   assign sltiu_s = (opnd_s_s < imm_se_s);

   // Decode op/funct and compute the raw result plus per-op flag sources.
   always_comb begin
      res_s   = 32'h0000_0000;
      valid_s = 1'b1;
      cmp_s   = 1'b0;
      ovf_s   = 1'b0;
      case (op_s)
         6'b000000: begin
            case (funct_s)
               6'b100000: begin res_s = sum_s;  ovf_s = add_ovf_s; end
               6'b100001: res_s = sum_s;
               6'b100010: begin res_s = diff_s; ovf_s = sub_ovf_s; end
               6'b100011: res_s = diff_s;
               6'b100100: res_s = opnd_s_s & opnd_t_s;
               6'b100101: res_s = opnd_s_s | opnd_t_s;
               6'b100110: res_s = opnd_s_s ^ opnd_t_s;
               6'b100111: res_s = ~(opnd_s_s | opnd_t_s);
               6'b101010: begin res_s = {31'd0, slt_s};  cmp_s = 1'b1; end
               6'b101011: begin res_s = {31'd0, sltu_s}; cmp_s = 1'b1; end
`ifdef ALU_SHIFT_EN
               6'b000000: res_s = opnd_t_s << bus.instruction[10:6];
               6'b000010: res_s = opnd_t_s >> bus.instruction[10:6];
               6'b000011: res_s = $signed(opnd_t_s) >>> bus.instruction[10:6];
               6'b000100: res_s = opnd_t_s << opnd_s_s[4:0];
               6'b000110: res_s = opnd_t_s >> opnd_s_s[4:0];
               6'b000111: res_s = $signed(opnd_t_s) >>> opnd_s_s[4:0];
`endif
               default:   valid_s = 1'b0;
            endcase
         end
         6'b001000: begin res_s = sum_imm_s; ovf_s = addi_ovf_s; end
         6'b001001: res_s = sum_imm_s;
         6'b001100: res_s = opnd_s_s & imm_ze_s;
         6'b001101: res_s = opnd_s_s | imm_ze_s;
         6'b001110: res_s = opnd_s_s ^ imm_ze_s;
         6'b001010: begin res_s = {31'd0, slti_s};  cmp_s = 1'b1; end
         6'b001011: begin res_s = {31'd0, sltiu_s}; cmp_s = 1'b1; end
         6'b000100: res_s = diff_s;
         6'b000101: res_s = diff_s;
         6'b100011: res_s = sum_imm_s;
         6'b101011: res_s = sum_imm_s;
         default:   valid_s = 1'b0;
      endcase
   end

   // Assemble flags; unsupported encodings force all flags low even though result is zero.
   always_comb begin
      flags_s = 3'b000;
      if (valid_s) begin
         flags_s[2] = (res_s == 32'h0000_0000);
         flags_s[1] = cmp_s ? res_s[0] : res_s[31];
         flags_s[0] = ovf_s;
      end else begin
         flags_s = 3'b000;
      end
   end

   // Output register stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.result <= 32'h0000_0000;
         bus.flags  <= 3'b000;
      end else if (valid_s) begin
         bus.result <= res_s;
         bus.flags  <= flags_s;
      end else begin
         bus.result <= 32'h0000_0000;
         bus.flags  <= 3'b000;
      end
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: spec-level reference model checked every cycle plus literal vectors.
module tb_alu;

   logic clk;
   logic rst_n;
   alu_if bus ();

   alu dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   logic chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] shamt, input logic [5:0] funct);
      return {6'b000000, rs, rt, 5'd0, shamt, funct};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Reference model: straight from the instruction-set rules, using 64-bit signed arithmetic.
   function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic [2:0] f);
      logic [31:0] s, t, se, ze;
      longint ls, lt, lse, wide;
      bit ok, cmp, ov;
      s  = ins[21] ? b : a;
      t  = ins[16] ? b : a;
      se = {{16{ins[15]}}, ins[15:0]};
      ze = {16'h0000, ins[15:0]};
      ls = longint'($signed(s));
      lt = longint'($signed(t));
      lse = longint'($signed(se));
      ok = 1'b1; cmp = 1'b0; ov = 1'b0; r = 32'd0; wide = 0;
      if (ins[31:26] == 6'd0) begin
         case (ins[5:0])
            6'h20: begin wide = ls + lt; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            6'h21: r = s + t;
            6'h22: begin wide = ls - lt; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            6'h23: r = s - t;
            6'h24: r = s & t;
            6'h25: r = s | t;
            6'h26: r = s ^ t;
            6'h27: r = ~(s | t);
            6'h2A: begin r = (ls < lt) ? 32'd1 : 32'd0; cmp = 1'b1; end
            6'h2B: begin r = (s < t) ? 32'd1 : 32'd0; cmp = 1'b1; end
`ifdef ALU_SHIFT_EN
            6'h00: r = t << ins[10:6];
            6'h02: r = t >> ins[10:6];
            6'h03: begin wide = lt >>> ins[10:6]; r = wide[31:0]; end
            6'h04: r = t << s[4:0];
            6'h06: r = t >> s[4:0];
            6'h07: begin wide = lt >>> s[4:0]; r = wide[31:0]; end
`endif
            default: ok = 1'b0;
         endcase
      end else begin
         case (ins[31:26])
            6'h08: begin wide = ls + lse; r = wide[31:0]; ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648); end
            6'h09, 6'h23, 6'h2B: r = s + se;
            6'h0C: r = s & ze;
            6'h0D: r = s | ze;
            6'h0E: r = s ^ ze;
            6'h0A: begin r = (ls < lse) ? 32'd1 : 32'd0; cmp = 1'b1; end
            6'h0B: begin r = (s < se) ? 32'd1 : 32'd0; cmp = 1'b1; end
            6'h04, 6'h05: r = s - t;
            default: ok = 1'b0;
         endcase
      end
      if (ok) f = {r == 32'd0, cmp ? (r != 32'd0) : r[31], ov};
      else begin r = 32'd0; f = 3'b000; end
   endfunction

   logic [31:0] exp_res;
   logic [2:0]  exp_flags;
   logic [31:0] m_res;
   logic [2:0]  m_flags;

   // Expected-output register mirrors the one-cycle latency and async clear.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_res   <= 32'd0;
         exp_flags <= 3'b000;
      end else begin
         model(bus.instruction, bus.regA, bus.regB, m_res, m_flags);
         exp_res   <= m_res;
         exp_flags <= m_flags;
      end
   end

   // Cycle-by-cycle compare on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model_result", bus.result, exp_res);
         check("model_flags", {29'd0, bus.flags}, {29'd0, exp_flags});
      end
   end

   task automatic apply(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.instruction = ins;
      bus.regA = a;
      bus.regB = b;
   endtask

   task automatic apply_check(input string name, input logic [31:0] ins, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic [2:0] ef);
      apply(ins, a, b);
      @(posedge clk);
      #1;
      check({name, "_result"}, bus.result, er);
      check({name, "_flags"}, {29'd0, bus.flags}, {29'd0, ef});
   endtask

   localparam int NV = 23;
   logic [31:0] v_ins [NV];
   logic [31:0] v_a   [NV];
   logic [31:0] v_b   [NV];

   initial begin
      logic [31:0] add_i;
      add_i = 32'h0001_4020;
      v_ins[0]  = rtype(5'd0, 5'd1, 5'd0, 6'h22);           v_a[0]  = 32'd5;          v_b[0]  = 32'd9;
      v_ins[1]  = rtype(5'd0, 5'd1, 5'd0, 6'h23);           v_a[1]  = 32'h8000_0000;  v_b[1]  = 32'd1;
      v_ins[2]  = rtype(5'd0, 5'd1, 5'd0, 6'h24);           v_a[2]  = 32'hF0F0_F0F0;  v_b[2]  = 32'hFF00_FF00;
      v_ins[3]  = rtype(5'd0, 5'd1, 5'd0, 6'h25);           v_a[3]  = 32'hF0F0_F0F0;  v_b[3]  = 32'hFF00_FF00;
      v_ins[4]  = rtype(5'd0, 5'd1, 5'd0, 6'h26);           v_a[4]  = 32'hF0F0_F0F0;  v_b[4]  = 32'hFF00_FF00;
      v_ins[5]  = rtype(5'd0, 5'd1, 5'd0, 6'h27);           v_a[5]  = 32'hF0F0_F0F0;  v_b[5]  = 32'h0F0F_0F0F;
      v_ins[6]  = itype(6'h0A, 5'd0, 5'd0, 16'hFFFF);       v_a[6]  = 32'hFFFF_FFFE;  v_b[6]  = 32'd0;
      v_ins[7]  = itype(6'h0B, 5'd0, 5'd0, 16'hFFFF);       v_a[7]  = 32'd5;          v_b[7]  = 32'd0;
      v_ins[8]  = itype(6'h0C, 5'd1, 5'd0, 16'h8F0F);       v_a[8]  = 32'd0;          v_b[8]  = 32'hFFFF_FFFF;
      v_ins[9]  = itype(6'h0E, 5'd0, 5'd0, 16'hFFFF);       v_a[9]  = 32'hFFFF_0000;  v_b[9]  = 32'd0;
      v_ins[10] = itype(6'h23, 5'd0, 5'd0, 16'hFFFC);       v_a[10] = 32'h0000_0100;  v_b[10] = 32'd0;
      v_ins[11] = itype(6'h2B, 5'd1, 5'd0, 16'h0004);       v_a[11] = 32'd0;          v_b[11] = 32'h7FFF_FFFE;
      v_ins[12] = itype(6'h05, 5'd0, 5'd1, 16'h0000);       v_a[12] = 32'd3;          v_b[12] = 32'd3;
      v_ins[13] = itype(6'h08, 5'd0, 5'd0, 16'h0001);       v_a[13] = 32'h7FFF_FFFF;  v_b[13] = 32'd0;
      v_ins[14] = itype(6'h09, 5'd0, 5'd0, 16'h0001);       v_a[14] = 32'h7FFF_FFFF;  v_b[14] = 32'd0;
      v_ins[15] = rtype(5'd0, 5'd1, 5'd0, 6'h00);           v_a[15] = 32'd0;          v_b[15] = 32'hDEAD_BEEF;
      v_ins[16] = rtype(5'd0, 5'd1, 5'd31, 6'h02);          v_a[16] = 32'd0;          v_b[16] = 32'h8000_0000;
      v_ins[17] = rtype(5'd0, 5'd1, 5'd0, 6'h04);           v_a[17] = 32'd36;         v_b[17] = 32'd1;
      v_ins[18] = rtype(5'd1, 5'd0, 5'd0, 6'h06);           v_a[18] = 32'h8000_0000;  v_b[18] = 32'h21;
      v_ins[19] = rtype(5'd0, 5'd1, 5'd0, 6'h07);           v_a[19] = 32'd31;         v_b[19] = 32'h8000_0000;
      v_ins[20] = itype(6'h02, 5'd0, 5'd1, 16'h1234);       v_a[20] = 32'd1;          v_b[20] = 32'd1;
      v_ins[21] = rtype(5'd0, 5'd1, 5'd0, 6'h08);           v_a[21] = 32'd1;          v_b[21] = 32'd1;
      v_ins[22] = rtype(5'd30, 5'd3, 5'd0, 6'h20);          v_a[22] = 32'd100;        v_b[22] = 32'd23;

      rst_n = 1'b0;
      bus.instruction = 32'd0;
      bus.regA = 32'd0;
      bus.regB = 32'd0;
      #2;
      check("reset_result", bus.result, 32'd0);
      check("reset_flags", {29'd0, bus.flags}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      apply_check("add_4_5",     add_i, 32'd4, 32'd5, 32'h0000_0009, 3'b000);
      apply_check("add_m4_6",    add_i, 32'hFFFF_FFFC, 32'd6, 32'h0000_0002, 3'b000);
      apply_check("add_zero",    add_i, 32'hFFFF_FFF6, 32'd10, 32'h0000_0000, 3'b100);
      apply_check("add_neg",     add_i, 32'hFFFF_FFF6, 32'd5, 32'hFFFF_FFFB, 3'b010);
      apply_check("add_ovf",     add_i, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 3'b011);
      apply_check("addu_noovf",  rtype(5'd0, 5'd1, 5'd0, 6'h21), 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 3'b010);
      apply_check("sub_ovf",     rtype(5'd0, 5'd1, 5'd0, 6'h22), 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 3'b001);
      apply_check("beq_eq",      itype(6'h04, 5'd0, 5'd1, 16'h0000), 32'h1234, 32'h1234, 32'h0000_0000, 3'b100);
      apply_check("slt",         rtype(5'd0, 5'd1, 5'd0, 6'h2A), 32'hFFFF_FFFF, 32'd1, 32'h0000_0001, 3'b010);
      apply_check("sltu",        rtype(5'd0, 5'd1, 5'd0, 6'h2B), 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 3'b100);
      apply_check("ori_zext",    itype(6'h0D, 5'd0, 5'd0, 16'h8001), 32'd0, 32'd0, 32'h0000_8001, 3'b000);
      apply_check("addi_sext",   itype(6'h08, 5'd1, 5'd0, 16'hFFFF), 32'd0, 32'd1, 32'h0000_0000, 3'b100);
      apply_check("unsup_op",    itype(6'h3F, 5'd0, 5'd0, 16'h0000), 32'd0, 32'd0, 32'h0000_0000, 3'b000);
`ifdef ALU_SHIFT_EN
      apply_check("sra",         rtype(5'd0, 5'd0, 5'd4, 6'h03), 32'hF000_0000, 32'd0, 32'hFF00_0000, 3'b010);
`else
      apply_check("sra_off",     rtype(5'd0, 5'd0, 5'd4, 6'h03), 32'hF000_0000, 32'd0, 32'h0000_0000, 3'b000);
`endif

      for (int i = 0; i < NV; i++) apply(v_ins[i], v_a[i], v_b[i]);

      // Asynchronous clear mid-stream, then resume on the next edge.
      apply(add_i, 32'd4, 32'd5);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_result", bus.result, 32'd0);
      check("async_rst_flags", {29'd0, bus.flags}, 32'd0);
      @(negedge clk);
      bus.regA = 32'd7;
      bus.regB = 32'd8;
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_result", bus.result, 32'd15);
      check("post_rst_flags", {29'd0, bus.flags}, 32'd0);

      apply(32'd0, 32'd0, 32'd0);
      repeat (3) @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
